// File: rtl/pid_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pid_pkg                                                   |
// | Purpose  : Default widths and gains for pid_term, plus the shared    |
// |            signed saturation helper used by every clamp.             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package pid_pkg;

  localparam int DEF_ERR_W   = 12;
  localparam int DEF_SAT_W   = 10;
  localparam int DEF_P_COEFF = 3;
  localparam int DEF_D_COEFF = 6;
  localparam int DEF_D_DEPTH = 4;
  localparam int DEF_D_SAT_W = 7;
  localparam int DEF_I_W     = 16;
  localparam int DEF_I_SHIFT = 4;
  localparam int DEF_PID_W   = 14;

  // Clamp a sign-extended 64-bit value into the signed range of out_w bits.
  // Callers keep only the low out_w bits of the result.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] val,
                                               input int                 out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (val > hi) begin
      sat_s = hi;
    end else if (val < lo) begin
      sat_s = lo;
    end else begin
      sat_s = val;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_clamp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sat_clamp                                                 |
// | Purpose  : Combinational signed saturator, IN_W bits down to OUT_W.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sat_clamp
  import pid_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  d_i,
  output logic [OUT_W-1:0] q_o
);

  // Sign-extend to the helper's width, clamp, keep the low OUT_W bits.
  assign q_o = OUT_W'(sat_s(64'(signed'(d_i)), OUT_W));

endmodule
`default_nettype wire

// File: rtl/pid_term.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pid_term                                                  |
// | Purpose  : Three-stage pipelined PID term generator. Saturates the   |
// |            input error, forms P, anti-windup I and N-sample D terms, |
// |            sums and saturates to the PID output width.               |
// | Options  : PID_TERM_DBG_EN adds p_dbg/i_dbg/d_dbg term taps and the  |
// |            sticky int_sat overflow-suppressed flag.                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pid_term
  import pid_pkg::*;
#(
  parameter int ERR_W   = DEF_ERR_W,
  parameter int SAT_W   = DEF_SAT_W,
  parameter int P_COEFF = DEF_P_COEFF,
  parameter int D_COEFF = DEF_D_COEFF,
  parameter int D_DEPTH = DEF_D_DEPTH,
  parameter int D_SAT_W = DEF_D_SAT_W,
  parameter int I_W     = DEF_I_W,
  parameter int I_SHIFT = DEF_I_SHIFT,
  parameter int PID_W   = DEF_PID_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ERR_W-1:0] error,
  input  logic             err_vld,
  input  logic             moving,
  input  logic             clr_int,
  output logic [SAT_W-1:0] err_sat,
  output logic [PID_W-1:0] pid,
  output logic             pid_vld
`ifdef PID_TERM_DBG_EN
  ,
  output logic [PID_W-1:0] p_dbg,
  output logic [PID_W-1:0] i_dbg,
  output logic [PID_W-1:0] d_dbg,
  output logic             int_sat
`endif
);

  localparam int P_W  = SAT_W + 4;    // proportional term width
  localparam int DF_W = SAT_W + 1;    // raw derivative difference width
  localparam int D_W  = D_SAT_W + 6;  // derivative term width
  localparam int S_W  = PID_W + 2;    // summation width ahead of the clamp

  localparam logic signed [3:0] P_GAIN = 4'(P_COEFF);
  localparam logic signed [5:0] D_GAIN = 6'(D_COEFF);

  // ---------------- stage 1: input saturation ----------------
  logic [SAT_W-1:0] w_err_clamp;
  logic [SAT_W-1:0] err_sat_q;
  logic             v1_q;
  logic             mov1_q;
  logic             clr1_q;

  sat_clamp #(.IN_W(ERR_W), .OUT_W(SAT_W)) u_in_clamp (
    .d_i (error),
    .q_o (w_err_clamp)
  );

  // Capture the clamped sample; moving/clr_int travel alongside so the
  // integrator acts on them in the same cycle as the matching sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sat_q <= '0;
      v1_q      <= 1'b0;
      mov1_q    <= 1'b0;
      clr1_q    <= 1'b0;
    end else begin
      v1_q   <= err_vld;
      mov1_q <= moving;
      clr1_q <= clr_int;
      if (err_vld) begin
        err_sat_q <= w_err_clamp;
      end
    end
  end

  // ---------------- stage 2: P, I, D ----------------
  logic [SAT_W-1:0]         hist_q [D_DEPTH];
  logic signed [I_W-1:0]    integ_q;
  logic signed [I_W-1:0]    integ_d;
  logic signed [P_W-1:0]    p_q;
  logic signed [I_W-1:0]    i_q;
  logic signed [D_W-1:0]    d_q;
  logic                     v2_q;

  logic signed [SAT_W-1:0]  w_es;
  logic signed [SAT_W-1:0]  w_hist_old;
  logic signed [P_W-1:0]    w_p;
  logic [DF_W-1:0]          w_diff;
  logic [D_SAT_W-1:0]       w_dsat;
  logic signed [D_W-1:0]    w_d;
  logic signed [I_W-1:0]    w_iterm;
  logic signed [I_W-1:0]    w_sum;
  logic                     w_ovf;

  assign w_es       = signed'(err_sat_q);
  assign w_hist_old = signed'(hist_q[D_DEPTH-1]);
  assign w_p        = P_W'(w_es) * P_W'(P_GAIN);
  assign w_diff     = DF_W'(w_es) - DF_W'(w_hist_old);

  sat_clamp #(.IN_W(DF_W), .OUT_W(D_SAT_W)) u_d_clamp (
    .d_i (w_diff),
    .q_o (w_dsat)
  );

  assign w_d     = D_W'(signed'(w_dsat)) * D_W'(D_GAIN);
  // The I term always reflects the integrator before this sample's update.
  assign w_iterm = integ_q >>> I_SHIFT;
  assign w_sum   = integ_q + I_W'(w_es);
  // Same-sign operands with a flipped result sign means the add wrapped.
  assign w_ovf   = (integ_q[I_W-1] == w_es[SAT_W-1]) &&
                   (w_sum[I_W-1] != integ_q[I_W-1]);

  // Integrator next state: clear beats accumulate; a wrapping add is dropped.
  always_comb begin
    integ_d = integ_q;
    if (clr1_q) begin
      integ_d = '0;
    end else if (v1_q && mov1_q && !w_ovf) begin
      integ_d = w_sum;
    end
  end

  // Register the three terms and shift the derivative history on each sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q     <= '0;
      i_q     <= '0;
      d_q     <= '0;
      v2_q    <= 1'b0;
      integ_q <= '0;
      for (int k = 0; k < D_DEPTH; k++) begin
        hist_q[k] <= '0;
      end
    end else begin
      v2_q    <= v1_q;
      integ_q <= integ_d;
      if (v1_q) begin
        p_q       <= w_p;
        i_q       <= w_iterm;
        d_q       <= w_d;
        hist_q[0] <= err_sat_q;
        for (int k = 1; k < D_DEPTH; k++) begin
          hist_q[k] <= hist_q[k-1];
        end
      end
    end
  end

  // ---------------- stage 3: sum and output clamp ----------------
  logic signed [S_W-1:0] w_total;
  logic [PID_W-1:0]      w_pid_clamp;
  logic [PID_W-1:0]      pid_q;
  logic                  pid_vld_q;

  assign w_total = S_W'(p_q) + S_W'(i_q) + S_W'(d_q);

  sat_clamp #(.IN_W(S_W), .OUT_W(PID_W)) u_out_clamp (
    .d_i (w_total),
    .q_o (w_pid_clamp)
  );

  // Publish the saturated sum; pid holds between valid strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pid_q     <= '0;
      pid_vld_q <= 1'b0;
    end else begin
      pid_vld_q <= v2_q;
      if (v2_q) begin
        pid_q <= w_pid_clamp;
      end
    end
  end

  assign err_sat = err_sat_q;
  assign pid     = pid_q;
  assign pid_vld = pid_vld_q;

`ifdef PID_TERM_DBG_EN
  logic int_sat_q;

  // Sticky record of any suppressed integrator overflow, reset by a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_sat_q <= 1'b0;
    end else if (clr1_q) begin
      int_sat_q <= 1'b0;
    end else if (v1_q && mov1_q && w_ovf) begin
      int_sat_q <= 1'b1;
    end
  end

  assign p_dbg   = PID_W'(p_q);
  assign i_dbg   = PID_W'(i_q);
  assign d_dbg   = PID_W'(d_q);
  assign int_sat = int_sat_q;
`endif

endmodule
`default_nettype wire
